// File: rtl/vga_scaled_framebuffer.sv
// VGA scan-out engine: sync timing plus upscaled fetch from an external synchronous framebuffer RAM.
// Outputs (syncs, colour, frame start) all trail the scan counters by RAM_LAT+1 clocks.
module vga_scaled_framebuffer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int SCALE     = 4,
  parameter int MODE      = 0,
  parameter int RAM_LAT   = 1,
  parameter int ADDR_W    = 13,
  parameter int BUF1_BASE = 2400
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              BufferSelect_i,
  output logic [ADDR_W-1:0] Address_o,
  input  logic [7:0]        Data_i,
  output logic              Red_o,
  output logic              Green_o,
  output logic              Blue_o,
  output logic              HSync_o,
  output logic              VSync_o,
  output logic              FrameStart_o,
  output logic              ActiveBuffer_o
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SCALE_SAFE = (SCALE < 1) ? 1 : SCALE;
  localparam int FB_W       = H_ACTIVE / SCALE_SAFE;
  localparam int FB_H       = V_ACTIVE / SCALE_SAFE;
  localparam int PIPE       = RAM_LAT + 1;
  localparam int BUF_WORDS  = (MODE == 0) ? FB_W * (FB_H / 8) : FB_W * FB_H;
  localparam int HW         = $clog2(H_TOTAL);
  localparam int VW         = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [2:0]    SUB_LAST = 3'(SCALE_SAFE - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  if (SCALE < 1 || SCALE > 8 || (H_ACTIVE % SCALE_SAFE) != 0 || (V_ACTIVE % SCALE_SAFE) != 0) begin : g_bad_scale
    $error("vga_scaled_framebuffer: SCALE must be 1..8 and divide H_ACTIVE and V_ACTIVE");
  end
  if (MODE == 0 && (FB_H % 8) != 0) begin : g_bad_height
    $error("vga_scaled_framebuffer: paged mono mode needs FB_H to be a multiple of 8");
  end
  if (RAM_LAT < 1 || RAM_LAT > 2) begin : g_bad_lat
    $error("vga_scaled_framebuffer: RAM_LAT must be 1 or 2");
  end
  if (ADDR_W > 30 || BUF1_BASE + BUF_WORDS > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("vga_scaled_framebuffer: ADDR_W cannot hold BUF1_BASE plus one buffer");
  end

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] ysel;
  } stage_t;

  localparam stage_t STAGE_RST = stage_t'({1'b0, ~HS_ON, ~VS_ON, 1'b0, 3'd0});

  logic [HW-1:0]     h_cnt_reg, x_reg;
  logic [VW-1:0]     v_cnt_reg, y_reg;
  logic [2:0]        x_sub_reg, y_sub_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              active_buffer_reg;
  stage_t            pipe_reg [PIPE];
  stage_t            stage_in, stage_out;
  logic              h_last, v_last, active;
  logic [31:0]       row, addr_full;
  logic [2:0]        rgb;

  assign h_last = (h_cnt_reg == H_LAST);
  assign v_last = (v_cnt_reg == V_LAST);

  // x/y are the framebuffer coordinates, stepped by SCALE-long sub-counters instead of dividing.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      x_sub_reg <= '0;
      y_sub_reg <= '0;
    end else if (h_last) begin
      h_cnt_reg <= '0;
      x_reg     <= '0;
      x_sub_reg <= '0;
      if (v_last) begin
        v_cnt_reg <= '0;
        y_reg     <= '0;
        y_sub_reg <= '0;
      end else begin
        v_cnt_reg <= v_cnt_reg + 1'b1;
        if (y_sub_reg == SUB_LAST) begin
          y_sub_reg <= '0;
          y_reg     <= y_reg + 1'b1;
        end else begin
          y_sub_reg <= y_sub_reg + 1'b1;
        end
      end
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
      if (x_sub_reg == SUB_LAST) begin
        x_sub_reg <= '0;
        x_reg     <= x_reg + 1'b1;
      end else begin
        x_sub_reg <= x_sub_reg + 1'b1;
      end
    end
  end

  always_comb begin
    active    = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    row       = (MODE == 0) ? 32'(y_reg >> 3) : 32'(y_reg);
    addr_full = (active_buffer_reg ? 32'(BUF1_BASE) : 32'd0) + row * 32'(FB_W) + 32'(x_reg);
    stage_in      = STAGE_RST;
    stage_in.act  = active;
    stage_in.hs   = (h_cnt_reg >= HS_FIRST && h_cnt_reg <= HS_LAST) ? HS_ON : ~HS_ON;
    stage_in.vs   = (v_cnt_reg >= VS_FIRST && v_cnt_reg <= VS_LAST) ? VS_ON : ~VS_ON;
    stage_in.fs   = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    stage_in.ysel = y_reg[2:0];
  end

  // Buffer select is only taken on the very last clock of a frame, so a swap never tears.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr_reg          <= '0;
      active_buffer_reg <= 1'b0;
    end else begin
      if (active) begin
        addr_reg <= addr_full[ADDR_W-1:0];
      end
      if (h_last && v_last) begin
        active_buffer_reg <= BufferSelect_i;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < PIPE; i++) pipe_reg[i] <= STAGE_RST;
    end else begin
      for (int i = PIPE - 1; i > 0; i--) pipe_reg[i] <= pipe_reg[i-1];
      pipe_reg[0] <= stage_in;
    end
  end

  assign stage_out = pipe_reg[PIPE-1];

  // Data_i arrives exactly as the matching stage reaches the end of the delay line.
  for (genvar gi = 0; gi < 3; gi++) begin : g_colour
    if (MODE == 0) begin : g_mono
      assign rgb[gi] = stage_out.act & Data_i[stage_out.ysel];
    end else begin : g_rgb
      assign rgb[gi] = stage_out.act & Data_i[gi];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr_full, stage_out.ysel, Data_i};

  assign Address_o      = addr_reg;
  assign ActiveBuffer_o = active_buffer_reg;
  assign Red_o          = rgb[2];
  assign Green_o        = rgb[1];
  assign Blue_o         = rgb[0];
  assign HSync_o        = stage_out.hs;
  assign VSync_o        = stage_out.vs;
  assign FrameStart_o   = stage_out.fs;

endmodule

// File: tb/tb_vga_scaled_framebuffer.sv
// Bench for vga_scaled_framebuffer: two configurations on small timings, random RAM and buffer
// selects, every output compared each cycle against a frame-arithmetic reference model.
module tb_vga_scaled_framebuffer;

  localparam int HA = 32, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 32, VFP = 2, VSY = 2, VBP = 2;
  localparam int LINE  = HA + HFP + HSY + HBP;
  localparam int FRAME = VA + VFP + VSY + VBP;
  localparam int FC    = LINE * FRAME;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] addr0;
  logic [8:0] addr1;
  logic [7:0] rd0, rd1, rd1_pre;
  logic       red0, grn0, blu0, hs0, vs0, fs0, ab0;
  logic       red1, grn1, blu1, hs1, vs1, fs1, ab1;

  logic [7:0] mem [2][512];
  int         sel_hist [8192];
  int         last_addr [2];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // dut0: paged mono, SCALE 4, RAM latency 1, active-low syncs
  vga_scaled_framebuffer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .SCALE(4), .MODE(0), .RAM_LAT(1),
    .ADDR_W(8), .BUF1_BASE(16)
  ) dut0 (
    .Clock(clk), .Reset(rst_n), .BufferSelect_i(sel), .Address_o(addr0), .Data_i(rd0),
    .Red_o(red0), .Green_o(grn0), .Blue_o(blu0), .HSync_o(hs0), .VSync_o(vs0),
    .FrameStart_o(fs0), .ActiveBuffer_o(ab0)
  );

  // dut1: byte-per-pixel RGB, SCALE 2, RAM latency 2, active-high syncs
  vga_scaled_framebuffer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1), .VS_POL(1), .SCALE(2), .MODE(1), .RAM_LAT(2),
    .ADDR_W(9), .BUF1_BASE(256)
  ) dut1 (
    .Clock(clk), .Reset(rst_n), .BufferSelect_i(sel), .Address_o(addr1), .Data_i(rd1),
    .Red_o(red1), .Green_o(grn1), .Blue_o(blu1), .HSync_o(hs1), .VSync_o(vs1),
    .FrameStart_o(fs1), .ActiveBuffer_o(ab1)
  );

  always @(posedge clk) rd0 <= mem[0][addr0];
  always @(posedge clk) begin
    rd1_pre <= mem[1][addr1];
    rd1     <= rd1_pre;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int pipe_of(int d);  return (d == 0) ? 2 : 3;    endfunction
  function automatic int scale_of(int d); return (d == 0) ? 4 : 2;    endfunction
  function automatic int base1_of(int d); return (d == 0) ? 16 : 256; endfunction

  // Buffer shown in frame n is whatever BufferSelect held on the last clock of frame n-1.
  function automatic int buf_of(int c);
    int f;
    f = c / FC;
    return (f == 0) ? 0 : sel_hist[f * FC - 1];
  endfunction

  function automatic logic is_active(int c);
    return ((c % LINE) < HA) && (((c / LINE) % FRAME) < VA);
  endfunction

  function automatic int addr_of(int d, int c);
    int x, y, fbw, base;
    x    = (c % LINE) / scale_of(d);
    y    = ((c / LINE) % FRAME) / scale_of(d);
    fbw  = HA / scale_of(d);
    base = (buf_of(c) != 0) ? base1_of(d) : 0;
    if (d == 0) return base + (y / 8) * fbw + x;
    return base + y * fbw + x;
  endfunction

  function automatic logic [1:0] exp_sync(int d, int p);
    int h, v;
    logic hon, von;
    hon = (d == 1);
    von = (d == 1);
    if (p < 0) return {~hon, ~von};
    h = p % LINE;
    v = (p / LINE) % FRAME;
    return {(h >= HA + HFP && h < HA + HFP + HSY) ? hon : ~hon,
            (v >= VA + VFP && v < VA + VFP + VSY) ? von : ~von};
  endfunction

  function automatic logic [2:0] exp_rgb(int d, int p);
    logic [7:0] w;
    int y;
    if (p < 0 || !is_active(p)) return 3'b000;
    w = mem[d][addr_of(d, p)];
    y = ((p / LINE) % FRAME) / scale_of(d);
    if (d == 0) return w[y % 8] ? 3'b111 : 3'b000;
    return w[2:0];
  endfunction

  function automatic logic [31:0] obs_val(int d, int what);
    case (what)
      0:       return (d == 0) ? 32'({hs0, vs0}) : 32'({hs1, vs1});
      1:       return (d == 0) ? 32'({red0, grn0, blu0}) : 32'({red1, grn1, blu1});
      2:       return (d == 0) ? 32'(fs0) : 32'(fs1);
      3:       return (d == 0) ? 32'(ab0) : 32'(ab1);
      default: return (d == 0) ? 32'(addr0) : 32'(addr1);
    endcase
  endfunction

  task automatic check_reset_values();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_sync%0d", d), obs_val(d, 0), 32'(exp_sync(d, -1)));
      check_eq($sformatf("rst_rgb%0d", d),  obs_val(d, 1), 32'd0);
      check_eq($sformatf("rst_fs%0d", d),   obs_val(d, 2), 32'd0);
      check_eq($sformatf("rst_buf%0d", d),  obs_val(d, 3), 32'd0);
      check_eq($sformatf("rst_addr%0d", d), obs_val(d, 4), 32'd0);
    end
  endtask

  // c = clocks since reset release, i.e. the counter value in this cycle.
  task automatic check_cycle(input int c);
    int p;
    for (int d = 0; d < 2; d++) begin
      p = c - pipe_of(d);
      if (c >= 1 && is_active(c - 1)) last_addr[d] = addr_of(d, c - 1);
      check_eq($sformatf("sync%0d", d), obs_val(d, 0), 32'(exp_sync(d, p)));
      check_eq($sformatf("rgb%0d", d),  obs_val(d, 1), 32'(exp_rgb(d, p)));
      check_eq($sformatf("fs%0d", d),   obs_val(d, 2), 32'((p >= 0) && (p % FC == 0)));
      check_eq($sformatf("buf%0d", d),  obs_val(d, 3), 32'(buf_of(c)));
      check_eq($sformatf("addr%0d", d), obs_val(d, 4), 32'(last_addr[d]));
    end
  endtask

  task automatic run_cycles(input int run, input int n);
    last_addr[0] = 0;
    last_addr[1] = 0;
    for (int c = 0; c < n; c++) begin
      check_cycle(c);
      if ($urandom_range(0, 199) == 0) sel = ~sel;
      sel_hist[c] = int'(sel);
      if (c % FC == FC - 1)
        $display("run %0d frame %0d scanned: %0d vectors, %0d miscompares so far", run, c / FC, n_vec, n_err);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 512; i++) mem[d][i] = 8'($urandom);
    sel = 1'($urandom_range(0, 1));

    #2 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_reset_values();
    end
    $display("reset hold: %0d vectors, %0d miscompares", n_vec, n_err);

    rst_n = 1'b1;
    #1;
    run_cycles(1, 2 * FC + 20 + int'($urandom_range(0, 10)));

    // asynchronous reset in the middle of a line: outputs must drop at once
    rst_n = 1'b0;
    #1;
    check_reset_values();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_values();
    end
    $display("mid-line reset: %0d vectors, %0d miscompares", n_vec, n_err);

    rst_n = 1'b1;
    #1;
    run_cycles(2, FC + FC / 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
